// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU decode and the sequential multiplier:
//   - ALUOP encodings (OP_ADD .. OP_OR)
//   - multiplier FSM state encoding (IDLE / RUN / DONE)
//   - is_mult_op(): true when an ALUOP selects the multiply operation
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_XOR  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_MULT = 3'b011;
    localparam logic [2:0] OP_SLT  = 3'b100;
    localparam logic [2:0] OP_NOR  = 3'b101;
    localparam logic [2:0] OP_AND  = 3'b110;
    localparam logic [2:0] OP_OR   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    function automatic logic is_mult_op(input logic [2:0] op);
        return (op == OP_MULT);
    endfunction

endpackage

// File: rtl/mult_seq_unit_if.sv
// ---------------------------------------------------------------------------
// mult_seq_unit_if
// Request/response bundle between the control path and the sequential
// multiplier.
//   master (control path): drives start, ALUOP, a, b; observes results
//   slave  (multiplier)  : drives busy, done, product, V
// ---------------------------------------------------------------------------
interface mult_seq_unit_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic [2:0]           ALUOP;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;
    logic                 V;

    modport master (
        output start, ALUOP, a, b,
        input  busy, done, product, V
    );

    modport slave (
        input  start, ALUOP, a, b,
        output busy, done, product, V
    );
endinterface

// File: rtl/add_nbit.sv
// ---------------------------------------------------------------------------
// add_nbit
// WIDTH-bit unsigned adder with carry-in fixed at zero.
//   i_a, i_b : addends
//   o_sum    : low WIDTH bits of the sum
//   o_cout   : carry out of the top bit
// ---------------------------------------------------------------------------
module add_nbit #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b};

endmodule

// File: rtl/mult_seq_unit.sv
// ---------------------------------------------------------------------------
// mult_seq_unit
// Multi-cycle unsigned shift-add multiplier for ALUOP 3'b011.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of mult_seq_unit_if
//           in : start, ALUOP, a, b
//           out: busy (RUN state), done (one-cycle pulse),
//                product (2*WIDTH, held until next completion),
//                V (upper WIDTH bits of product nonzero)
// One multiply takes WIDTH+1 cycles: the accept edge plus WIDTH steps.
// ---------------------------------------------------------------------------
module mult_seq_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    mult_seq_unit_if.slave  bus
);

    mult_state_t         r_state;
    mult_state_t         w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [WIDTH-1:0]    r_m;
    logic [2*WIDTH-1:0]  r_p;
    logic [2*WIDTH-1:0]  r_product;
    logic                r_v;
    logic                r_busy;
    logic                r_done;

    logic                w_accept;
    logic                w_last;
    logic                w_busy_nxt;
    logic                w_done_nxt;
    logic [WIDTH-1:0]    w_sum;
    logic                w_cout;
    logic [WIDTH-1:0]    w_hi_nxt;
    logic                w_c_nxt;
    logic [2*WIDTH-1:0]  w_p_step;

    // A new operation is only taken when not iterating; DONE allows back-to-back.
    assign w_accept = bus.start && is_mult_op(bus.ALUOP) &&
                      ((r_state == IDLE) || (r_state == DONE));
    assign w_last   = (r_state == RUN) && (r_cnt == CNT_W'(WIDTH - 1));

    add_nbit #(.WIDTH(WIDTH)) u_add (
        .i_a    (r_p[2*WIDTH-1:WIDTH]),
        .i_b    (r_m),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // Partial-product step: conditionally add M into the upper half, keep the carry.
    always_comb begin
        w_hi_nxt = r_p[2*WIDTH-1:WIDTH];
        w_c_nxt  = 1'b0;
        if (r_p[0]) begin
            w_hi_nxt = w_sum;
            w_c_nxt  = w_cout;
        end else begin
            w_hi_nxt = r_p[2*WIDTH-1:WIDTH];
            w_c_nxt  = 1'b0;
        end
    end

    // The carry lands in bit 2W-1 so no product bit is lost on the shift.
    assign w_p_step = {w_c_nxt, w_hi_nxt, r_p[WIDTH-1:1]};

    // Next-state logic of the control FSM.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            DONE: begin
                if (w_accept) begin
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Status outputs decoded from the next state so they can be registered.
    always_comb begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (w_state_nxt)
            IDLE: begin
                w_busy_nxt = 1'b0;
                w_done_nxt = 1'b0;
            end
            RUN: begin
                w_busy_nxt = 1'b1;
                w_done_nxt = 1'b0;
            end
            DONE: begin
                w_busy_nxt = 1'b0;
                w_done_nxt = 1'b1;
            end
            default: begin
                w_busy_nxt = 1'b0;
                w_done_nxt = 1'b0;
            end
        endcase
    end

    // State register and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Operand load, iteration counter, shift register and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m       <= {WIDTH{1'b0}};
            r_p       <= {(2*WIDTH){1'b0}};
            r_cnt     <= {CNT_W{1'b0}};
            r_product <= {(2*WIDTH){1'b0}};
            r_v       <= 1'b0;
        end else if (w_accept) begin
            r_m   <= bus.a;
            r_p   <= {{WIDTH{1'b0}}, bus.b};
            r_cnt <= {CNT_W{1'b0}};
        end else if (r_state == RUN) begin
            r_p   <= w_p_step;
            r_cnt <= r_cnt + CNT_W'(1);
            // product and V only move on the final step; they hold otherwise.
            if (w_last) begin
                r_product <= w_p_step;
                r_v       <= |w_p_step[2*WIDTH-1:WIDTH];
            end
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.product = r_product;
    assign bus.V       = r_v;

endmodule

// File: tb/tb_mult_seq_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_seq_unit
// Self-checking bench for mult_seq_unit. Expected products come from plain
// 64-bit multiplication of the zero-extended operands.
// ---------------------------------------------------------------------------
module tb_mult_seq_unit;

    localparam int W = 32;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    logic [2*W-1:0] exp_prod;
    logic           exp_v;

    mult_seq_unit_if #(.WIDTH(W)) bus ();

    mult_seq_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] xx;
        logic [2*W-1:0] yy;
        xx = {{W{1'b0}}, x};
        yy = {{W{1'b0}}, y};
        return xx * yy;
    endfunction

    // Present one request for a single rising edge, then scramble the operands.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [2:0] op);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = ia;
        bus.b     = ib;
        bus.ALUOP = op;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        bus.ALUOP = 3'($urandom_range(0, 7));
    endtask

    // Observe `window` cycles after an accept edge; optionally inject a start at cycle inj_at.
    task automatic watch(input int window, input int inj_at, input logic [W-1:0] ia,
                         input logic [W-1:0] ib, input bit active,
                         output int first_done, output int n_done, output int busy_bad);
        logic busy_exp;
        first_done = -1;
        n_done     = 0;
        busy_bad   = 0;
        for (int n = 1; n <= window; n++) begin
            if (n == inj_at) begin
                bus.start = 1'b1;
                bus.a     = ia;
                bus.b     = ib;
                bus.ALUOP = 3'b011;
            end
            @(negedge clk);
            if (n == inj_at) bus.start = 1'b0;
            busy_exp = active && (n < W);
            if (bus.busy !== busy_exp) busy_bad++;
            if (bus.done === 1'b1) begin
                n_done++;
                if (first_done < 0) first_done = n;
            end
        end
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.ALUOP = 3'b000;
        repeat (3) @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
        total++; if (bus.product !== 64'd0) begin bad++; $display("FAIL reset_product got=%h want=0", bus.product); end
        total++; if (bus.V !== 1'b0) begin bad++; $display("FAIL reset_V got=%b want=0", bus.V); end
        rst_n = 1'b1;
        exp_prod = 64'd0;
        exp_v    = 1'b0;
    endtask

    task automatic test_mult(input string name, input logic [W-1:0] ia, input logic [W-1:0] ib);
        int fd, nd, bb;
        exp_prod = ref_mul(ia, ib);
        exp_v    = (exp_prod[2*W-1:W] != '0);
        issue(ia, ib, 3'b011);
        watch(W + 8, 0, '0, '0, 1'b1, fd, nd, bb);
        total++; if (fd !== W) begin bad++; $display("FAIL %s_latency got=%0d want=%0d", name, fd, W); end
        total++; if (nd !== 1) begin bad++; $display("FAIL %s_done_count got=%0d want=1", name, nd); end
        total++; if (bb !== 0) begin bad++; $display("FAIL %s_busy got=%0d bad cycles want=0", name, bb); end
        total++; if (bus.product !== exp_prod) begin bad++; $display("FAIL %s_product a=%h b=%h got=%h want=%h", name, ia, ib, bus.product, exp_prod); end
        total++; if (bus.V !== exp_v) begin bad++; $display("FAIL %s_V got=%b want=%b", name, bus.V, exp_v); end
    endtask

    task automatic test_ignore_restart;
        int fd, nd, bb;
        exp_prod = ref_mul(32'd7, 32'd9);
        exp_v    = 1'b0;
        issue(32'd7, 32'd9, 3'b011);
        watch(W + 8, 10, 32'd2, 32'd2, 1'b1, fd, nd, bb);
        total++; if (fd !== W) begin bad++; $display("FAIL restart_latency got=%0d want=%0d", fd, W); end
        total++; if (nd !== 1) begin bad++; $display("FAIL restart_done_count got=%0d want=1", nd); end
        total++; if (bb !== 0) begin bad++; $display("FAIL restart_busy got=%0d bad cycles want=0", bb); end
        total++; if (bus.product !== exp_prod) begin bad++; $display("FAIL restart_product got=%h want=%h", bus.product, exp_prod); end
    endtask

    task automatic test_bad_op;
        int fd, nd, bb;
        issue(32'd4, 32'd4, 3'b010);
        watch(40, 0, '0, '0, 1'b0, fd, nd, bb);
        total++; if (nd !== 0) begin bad++; $display("FAIL badop_done got=%0d pulses want=0", nd); end
        total++; if (bb !== 0) begin bad++; $display("FAIL badop_busy got=%0d bad cycles want=0", bb); end
        total++; if (bus.product !== exp_prod) begin bad++; $display("FAIL badop_product got=%h want=%h", bus.product, exp_prod); end
        total++; if (bus.V !== exp_v) begin bad++; $display("FAIL badop_V got=%b want=%b", bus.V, exp_v); end
    endtask

    task automatic test_reset_mid_run;
        int fd, nd, bb;
        issue(32'd100, 32'd100, 3'b011);
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b want=0", bus.done); end
        total++; if (bus.product !== 64'd0) begin bad++; $display("FAIL midrst_product got=%h want=0", bus.product); end
        total++; if (bus.V !== 1'b0) begin bad++; $display("FAIL midrst_V got=%b want=0", bus.V); end
        @(negedge clk);
        rst_n = 1'b1;
        exp_prod = 64'd0;
        exp_v    = 1'b0;
        watch(40, 0, '0, '0, 1'b0, fd, nd, bb);
        total++; if (nd !== 0) begin bad++; $display("FAIL midrst_late_done got=%0d pulses want=0", nd); end
        total++; if (bb !== 0) begin bad++; $display("FAIL midrst_late_busy got=%0d bad cycles want=0", bb); end
    endtask

    task automatic test_back_to_back;
        int fd, nd, bb;
        int seen;
        seen = -1;
        issue(32'd6, 32'd7, 3'b011);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                seen = n;
                break;
            end
        end
        total++; if (seen !== W) begin bad++; $display("FAIL b2b_first_latency got=%0d want=%0d", seen, W); end
        total++; if (bus.product !== 64'd42) begin bad++; $display("FAIL b2b_first_product got=%h want=%h", bus.product, 64'd42); end
        // Request sits on the bus during the DONE cycle.
        bus.start = 1'b1;
        bus.a     = 32'd10;
        bus.b     = 32'd0;
        bus.ALUOP = 3'b011;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_rebusy got=%b want=1", bus.busy); end
        total++; if (bus.product !== 64'd42) begin bad++; $display("FAIL b2b_hold_product got=%h want=%h", bus.product, 64'd42); end
        watch(W + 8, 0, '0, '0, 1'b1, fd, nd, bb);
        total++; if (fd !== W) begin bad++; $display("FAIL b2b_second_latency got=%0d want=%0d", fd, W); end
        total++; if (nd !== 1) begin bad++; $display("FAIL b2b_second_count got=%0d want=1", nd); end
        total++; if (bus.product !== 64'd0) begin bad++; $display("FAIL b2b_second_product got=%h want=0", bus.product); end
        total++; if (bus.V !== 1'b0) begin bad++; $display("FAIL b2b_second_V got=%b want=0", bus.V); end
        exp_prod = 64'd0;
        exp_v    = 1'b0;
    endtask

    task automatic test_random;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 3 == 1) rb = rb & 32'h0000_FFFF;
            if (i % 4 == 2) ra = ra | 32'h8000_0000;
            test_mult($sformatf("rand%0d", i), ra, rb);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_mult("small", 32'd3, 32'd5);
        test_bad_op();
        test_mult("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        test_ignore_restart();
        test_reset_mid_run();
        test_back_to_back();
        test_mult("zero_a", 32'd0, 32'hDEAD_BEEF);
        test_mult("carry", 32'h8000_0000, 32'h0000_0003);
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_seq_unit.md
Name: mult_seq_unit

Overview:
- Multi-cycle unsigned shift-add multiplier that executes ALUOP 3'b011 (mult). The combinational ALU slices tie their mult result to 0.
- Sits beside the 32-bit ALU. The control path sends the operands and ALUOP here, then waits on a start/busy/done handshake.
- Returns a 2*WIDTH-bit product and an unsigned overflow flag, matching the ALU's mult V semantics (carry-out based, unsigned).

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse/level, sampled on rising edge.
- ALUOP  input  3  operation code; only 3'b011 is accepted.
- a  input  WIDTH  multiplicand, captured on accepted start.
- b  input  WIDTH  multiplier, captured on accepted start.
- busy  output  1  high while iterating (RUN state).
- done  output  1  one-cycle pulse; result valid.
- product  output  2*WIDTH  registered result; holds until next completion.
- V  output  1  unsigned overflow: upper WIDTH bits of product nonzero.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, product=0, V=0, counter=0, internal regs=0.
  - Release is synchronous to clk.
- Accept condition: start=1 AND ALUOP==3'b011 AND state in {IDLE, DONE}, sampled on a rising edge.
  - start with any other ALUOP is ignored: no state change, no done.
  - start while in RUN is ignored.
- FSM states:
  - IDLE: busy=0, done=0. On accept: M<=a, P<={WIDTH'b0, b}, cnt<=0, go RUN.
  - RUN: busy=1, done=0. Each edge performs one step:
    - if P[0]=1, {c, hi} = P[2W-1:W] + M (WIDTH+1 bits, carry kept); else {c, hi} = {0, P[2W-1:W]}.
    - P <= {c, hi, P[W-1:1]}.
    - cnt <= cnt+1.
    - The step with cnt==WIDTH-1 is the last: product <= stepped P, V <= |stepped P[2W-1:W], go DONE.
  - DONE: busy=0, done=1 for exactly one cycle. Next edge: accept → RUN (back-to-back, new operands loaded), else → IDLE.
- Latency: start accepted at edge 0. Steps occur at edges 1..WIDTH. done is high between edge WIDTH and WIDTH+1.
  - Throughput: one multiply per WIDTH+1 cycles.
- product and V change only on the final RUN step and on reset. They hold their values through IDLE and through a following RUN.
- Arithmetic is unsigned only. The carry from the add is never lost: the WIDTH+1-bit sum shifts into bit 2W-1.
- Operand changes on a/b/ALUOP during RUN have no effect.
- rst_n asserted mid-RUN: operation aborted, no done, all outputs return to reset values immediately.
- Zero operands are legal and still take the full WIDTH+1 cycles (no early termination).

Decomposition:
- Shared package alu_pkg:
  - ALUOP constants OP_ADD=3'b000, OP_XOR=3'b001, OP_SUB=3'b010, OP_MULT=3'b011, OP_SLT=3'b100, OP_NOR=3'b101, OP_AND=3'b110, OP_OR=3'b111.
  - State encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Used by both ALU decode and this block.
- One sub-module add_nbit (WIDTH-bit ripple adder, cin tied 0, cout exposed) provides the partial-sum add.
- FSM, counter and shift register stay in mult_seq_unit.

Test Plan:
- a=3, b=5, ALUOP=011, start for 1 cycle → busy high for cycles 1..32; done pulses exactly at cycle 33 with product=64'd15, V=0.
- a=32'hFFFFFFFF, b=32'hFFFFFFFF → done at cycle 33; product=64'hFFFFFFFE00000001, V=1.
- a=7, b=9 started; start re-asserted with a=2, b=2 at cycle 10 → ignored; product=63, a single done pulse.
- start with ALUOP=010 (sub), a=4, b=4 → busy stays 0, no done for 40 cycles, product keeps its previous value.
- a=100, b=100 started; rst_n pulled low at cycle 15 → busy, done, product, V all 0 immediately; no done afterward until a new start.
- Back-to-back: a=6, b=7 completes; start with a=10, b=0 held during the DONE cycle → product=42 at the first done, busy re-asserts next cycle, second done 33 cycles later with product=0, V=0.
